// File: rtl/dff_arb_pkg.sv
// rtl/dff_arb_pkg.sv - shared types and helpers for the dff round-robin write arbiter
package dff_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, COMMIT, GAP} arb_state_t;

  localparam int GAP_W = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set req at or after rr_ptr
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Scan farthest-first so the candidate nearest rr_ptr is the last one written.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      idx = sum[IW-1:0];
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_rr_write_arbiter.sv
// rtl/dff_rr_write_arbiter.sv - round-robin sequencer for the single write port of a shared register
module dff_rr_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int MIN_GAP = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         q,
  output logic                      upd,
  output logic [IW-1:0]             owner,
  output logic                      busy
);

  arb_state_t          state, state_n;
  logic [NUM_REQ-1:0]  gnt_n;
  logic [DATA_W-1:0]   q_n;
  logic                upd_n;
  logic [IW-1:0]       owner_n;
  logic [IW-1:0]       rr_ptr, rr_ptr_n;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_n;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;
  logic [DATA_W-1:0]   wd_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign wd_arr[i] = wdata[i*DATA_W +: DATA_W];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      q       <= RESET_VAL;
      upd     <= 1'b0;
      owner   <= '0;
      rr_ptr  <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      q       <= q_n;
      upd     <= upd_n;
      owner   <= owner_n;
      rr_ptr  <= rr_ptr_n;
      gap_cnt <= gap_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = '0;
    q_n       = q;
    upd_n     = 1'b0;
    owner_n   = owner;
    rr_ptr_n  = rr_ptr;
    gap_cnt_n = gap_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_n[pick_idx] = 1'b1;
          owner_n         = pick_idx;
          rr_ptr_n        = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_n         = GRANT;
        end
      end
      GRANT: begin
        // A requester that lets go during its grant forfeits the slot; the pointer still moves on.
        if (req[owner]) begin
          q_n     = wd_arr[owner];
          upd_n   = 1'b1;
          state_n = COMMIT;
        end else begin
          state_n = IDLE;
        end
      end
      COMMIT: begin
        if (MIN_GAP > 0) begin
          gap_cnt_n = GAP_W'(MIN_GAP);
          state_n   = GAP;
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          gap_cnt_n = '0;
          state_n   = IDLE;
        end else begin
          gap_cnt_n = gap_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dff_rr_write_arbiter.sv
// tb/tb_dff_rr_write_arbiter.sv - directed and randomized bench for dff_rr_write_arbiter
module tb_dff_rr_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int G = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0, req2 = '0;
  logic [N*W-1:0] wdata = '0, wdata2 = '0;
  logic [N-1:0]   gnt, gnt2;
  logic [W-1:0]   q, q2;
  logic           upd, upd2, busy, busy2;
  logic [1:0]     owner, owner2;

  dff_rr_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .MIN_GAP(G)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .gnt(gnt), .q(q), .upd(upd), .owner(owner), .busy(busy));

  dff_rr_write_arbiter #(.NUM_REQ(N), .DATA_W(W), .MIN_GAP(0)) dut_nogap (
    .clk(clk), .reset(reset), .req(req2), .wdata(wdata2),
    .gnt(gnt2), .q(q2), .upd(upd2), .owner(owner2), .busy(busy2));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: tracks when the arbiter is next free rather than its states.
  int           m_ptr = 0, m_owner = 0, m_free = 0, m_cyc = 0;
  bit           m_gp = 0;
  logic [W-1:0] m_q = '0;
  logic [N-1:0] e_gnt = '0;
  bit           e_upd = 0, e_busy = 0;

  task automatic model_step();
    int w;
    m_cyc++;
    e_gnt = '0;
    e_upd = 0;
    if (reset) begin
      m_ptr = 0; m_owner = 0; m_q = '0; m_gp = 0; m_free = m_cyc + 1;
    end else if (m_gp) begin
      m_gp = 0;
      if (req[m_owner]) begin
        m_q   = wdata[m_owner*W +: W];
        e_upd = 1;
      end else begin
        m_free = m_cyc + 1;
      end
    end else if (m_cyc >= m_free && req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      e_gnt[w] = 1'b1;
      m_owner  = w;
      m_ptr    = (w + 1) % N;
      m_gp     = 1;
      m_free   = m_cyc + 3 + G;
    end
    e_busy = (m_cyc + 1 < m_free);
  endtask

  task automatic rand_cycle();
    @(negedge clk);
    chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
    chk("rnd_q", 32'(q), 32'(m_q));
    chk("rnd_upd", 32'(upd), 32'(e_upd));
    chk("rnd_owner", 32'(owner), 32'(m_owner));
    chk("rnd_busy", 32'(busy), 32'(e_busy));
    chk("rnd_onehot0", 32'($onehot0(gnt)), 32'd1);
    reset = ($urandom_range(0, 59) == 0);
    for (int i = 0; i < N; i++) begin
      if (reset) req[i] = 1'b0;
      else if (m_gp && m_owner == i) begin
        if ($urandom_range(0, 4) == 0) req[i] = 1'b0;
      end else if (e_upd && m_owner == i) req[i] = 1'b0;
      else if (!req[i] && $urandom_range(0, 2) == 0) begin
        req[i] = 1'b1;
        wdata[i*W +: W] = W'($urandom);
      end
    end
    model_step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    req2 = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int gt[$];
  int gi[$];

  initial begin
    // reset holds everything quiet
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_upd", 32'(upd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;

    // single write latency
    req = 4'b0100;
    wdata[2*W +: W] = 8'hA5;
    @(negedge clk);
    chk("lat_gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    chk("lat_q", 32'(q), 32'hA5);
    chk("lat_upd", 32'(upd), 32'd1);
    req = '0;
    @(negedge clk);
    chk("lat_busy3", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_busy4", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_busy5", 32'(busy), 32'd0);
    chk("lat_owner", 32'(owner), 32'd2);

    // all requesting: rotation and spacing
    do_reset();
    req = 4'b1111;
    wdata = 32'h44332211;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      chk("rr_onehot0", 32'($onehot0(gnt)), 32'd1);
      for (int i = 0; i < N; i++)
        if (gnt[i]) begin gt.push_back(c); gi.push_back(i); end
    end
    req = '0;
    chk("rr_count", 32'(gt.size()), 32'd5);
    for (int k = 0; k < gt.size() && k < 5; k++) begin
      chk("rr_index", 32'(gi[k]), 32'(k % N));
      chk("rr_time", 32'(gt[k]), 32'(1 + 5 * k));
    end

    // abort during grant
    do_reset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    req = 4'b0010;
    wdata[1*W +: W] = 8'h33;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'h2);
    req = 4'b1101;
    wdata[2*W +: W] = 8'h44;
    @(negedge clk);
    chk("abort_upd", 32'(upd), 32'd0);
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("abort_next_gnt", 32'(gnt), 32'h4);
    req = '0;
    @(negedge clk);

    // reset in COMMIT
    do_reset();
    req = 4'b0001;
    wdata[0 +: W] = 8'h5A;
    @(negedge clk);
    chk("rc_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    chk("rc_upd_pre", 32'(upd), 32'd1);
    chk("rc_q_pre", 32'(q), 32'h5A);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    chk("rc_q", 32'(q), 32'h00);
    chk("rc_gnt0", 32'(gnt), 32'd0);
    chk("rc_upd", 32'(upd), 32'd0);
    chk("rc_busy", 32'(busy), 32'd0);
    chk("rc_owner", 32'(owner), 32'd0);
    reset = 1'b0;
    req = 4'b0011;
    @(negedge clk);
    chk("rc_ptr0_gnt", 32'(gnt), 32'h1);
    req = '0;
    @(negedge clk);

    // no cooldown: one grant every 3 cycles
    do_reset();
    req2 = 4'b0001;
    wdata2[0 +: W] = 8'h77;
    gt.delete();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (gnt2 != '0) gt.push_back(c);
    end
    req2 = '0;
    chk("ng_count", 32'(gt.size()), 32'd4);
    for (int k = 0; k < gt.size() && k < 4; k++)
      chk("ng_time", 32'(gt[k]), 32'(1 + 3 * k));
    chk("ng_q", 32'(q2), 32'h77);

    // randomized traffic against the reference
    reset = 1'b1;
    req = '0;
    model_step();
    for (int c = 0; c < 2000; c++) rand_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
